// File: rtl/rle_zero_encoder.sv
// Zero run-length encoder: turns a zig-zag coefficient stream into (run, value, eob) tokens.
// Optional block token statistics are enabled with macro RLE_STATS_EN.
module rle_zero_encoder #(
  parameter int DATA_W    = 8,
  parameter int RUN_W     = 4,
  parameter int BLOCK_LEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RUN_W-1:0]  out_run,
  output logic [DATA_W-1:0] out_value,
  output logic              out_eob,
  output logic              err_last
`ifdef RLE_STATS_EN
  ,
  output logic [7:0]        stat_tokens,
  output logic              stat_valid
`endif
);

  localparam int IDX_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [RUN_W-1:0] RUN_MAX  = '1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLOCK_LEN - 1);

  logic [IDX_W-1:0] idx;
  logic [RUN_W-1:0] run;
  logic             rdy_en;
  logic             accept, retire, is_zero, is_last, emit;

  assign is_zero  = (in_data == '0);
  assign is_last  = (idx == IDX_LAST);
  // A zero produces a token only at block end or when the run field would overflow.
  assign emit     = !is_zero || is_last || (run == RUN_MAX);
  assign in_ready = rdy_en && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign retire   = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_en <= 1'b0;
    else     rdy_en <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      run       <= '0;
      out_valid <= 1'b0;
      out_run   <= '0;
      out_value <= '0;
      out_eob   <= 1'b0;
      err_last  <= 1'b0;
    end else begin
      if (accept) begin
        idx <= is_last ? '0 : idx + IDX_W'(1);
        if (in_last != is_last) err_last <= 1'b1;
        if (emit) begin
          out_valid <= 1'b1;
          out_run   <= is_zero ? (is_last ? '0 : RUN_MAX) : run;
          out_value <= in_data;
          out_eob   <= is_last;
          run       <= '0;
        end else begin
          run <= run + RUN_W'(1);
          if (retire) out_valid <= 1'b0;
        end
      end else if (retire) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef RLE_STATS_EN
  logic [7:0] tok_cnt;

  // Count is latched when the eob token loads, so it is stable by the time it retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tok_cnt     <= '0;
      stat_tokens <= '0;
    end else if (accept && emit) begin
      if (is_last) begin
        tok_cnt     <= '0;
        stat_tokens <= tok_cnt + 8'd1;
      end else begin
        tok_cnt <= tok_cnt + 8'd1;
      end
    end
  end

  assign stat_valid = retire && out_eob;
`endif

endmodule

// File: tb/tb_rle_zero_encoder.sv
// Directed bench for rle_zero_encoder: block-level token model plus per-cycle output checker.
module tb_rle_zero_encoder;
  logic       clk = 1'b0, rst = 1'b1;
  logic       in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_ready, out_valid, out_eob, err_last;
  logic [7:0] out_value;
  logic [3:0] out_run;
`ifdef RLE_STATS_EN
  logic [7:0] stat_tokens;
  logic       stat_valid;
`endif

  rle_zero_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_run(out_run), .out_value(out_value),
    .out_eob(out_eob), .err_last(err_last)
`ifdef RLE_STATS_EN
    , .stat_tokens(stat_tokens), .stat_valid(stat_valid)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [3:0] run; logic [7:0] val; logic eob;} tok_t;
  typedef logic [7:0] blk_t [64];

  tok_t exp_q[$];
  tok_t mq[$];
  int   stq[$];
  int   tests = 0, fails = 0, tok_no = 0;
  bit   chk_en = 1'b0;
  bit   held = 1'b0;
  tok_t hold_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Whole-block model: each nonzero carries the zeros before it; every 16 pending
  // zeros become a ZRL; the final sample always closes the block.
  function automatic void gen(input blk_t b);
    int z = 0;
    mq.delete();
    for (int i = 0; i < 63; i++) begin
      if (b[i] != 0) begin
        mq.push_back(tok_t'{4'(z), b[i], 1'b0});
        z = 0;
      end else begin
        z++;
        if (z == 16) begin
          mq.push_back(tok_t'{4'd15, 8'd0, 1'b0});
          z = 0;
        end
      end
    end
    if (b[63] != 0) mq.push_back(tok_t'{4'(z), b[63], 1'b1});
    else            mq.push_back(tok_t'{4'd0, 8'd0, 1'b1});
  endfunction

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, !out_valid || out_ready});
      if (held && out_valid) chk("hold", {out_run, out_value, out_eob}, hold_t);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_token: got run=%0d val=%0d eob=%0d, expected none",
                   out_run, out_value, out_eob);
        end else begin
          chk($sformatf("token%0d", tok_no), {out_run, out_value, out_eob}, exp_q.pop_front());
        end
        tok_no++;
`ifdef RLE_STATS_EN
        chk("stat_valid", {31'd0, stat_valid}, {31'd0, out_eob});
        if (out_eob && stq.size() != 0) chk("stat_tokens", stat_tokens, stq.pop_front());
`endif
      end
      held   = out_valid && !out_ready;
      hold_t = {out_run, out_value, out_eob};
    end else begin
      held = 1'b0;
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    bit ok = 1'b0;
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!ok && n < 100) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1; n++;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready got 0 for 100 cycles, expected 1");
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic run_block(input blk_t b, input int n, input int bad_at, input int stall_at);
    gen(b);
    foreach (mq[k]) exp_q.push_back(mq[k]);
    stq.push_back(mq.size());
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        out_ready = 1'b0;
        fork
          begin
            repeat (5) @(posedge clk);
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
          end
        join_none
      end
      send(b[i], (i == 63) || (i == bad_at));
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); n++;
    end
    @(posedge clk); #1;
    chk("drain_left", exp_q.size(), 0);
  endtask

  blk_t b;

  initial begin
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_run", {28'd0, out_run}, 0);
    chk("rst_out_value", {24'd0, out_value}, 0);
    chk("rst_out_eob", {31'd0, out_eob}, 0);
    chk("rst_err_last", {31'd0, err_last}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk_en = 1'b1;

    // DC then 63 zeros
    foreach (b[i]) b[i] = 8'd0;
    b[0] = 8'd5;
    gen(b);
    chk("m1_size", mq.size(), 5);
    chk("m1_dc", mq[0], tok_t'{4'd0, 8'd5, 1'b0});
    chk("m1_zrl", mq[1], tok_t'{4'd15, 8'd0, 1'b0});
    chk("m1_eob", mq[4], tok_t'{4'd0, 8'd0, 1'b1});
    run_block(b, 64, -1, -1);
    drain();
    chk("err_last_clean", {31'd0, err_last}, 0);

    // all nonzero
    foreach (b[i]) b[i] = 8'(i + 1);
    gen(b);
    chk("m2_size", mq.size(), 64);
    chk("m2_pen", mq[62], tok_t'{4'd0, 8'd63, 1'b0});
    chk("m2_last", mq[63], tok_t'{4'd0, 8'd64, 1'b1});
    run_block(b, 64, -1, -1);
    drain();

    // 16 zeros, then 7
    foreach (b[i]) b[i] = 8'd0;
    b[16] = 8'd7;
    gen(b);
    chk("m3_size", mq.size(), 5);
    chk("m3_zrl", mq[0], tok_t'{4'd15, 8'd0, 1'b0});
    chk("m3_val", mq[1], tok_t'{4'd0, 8'd7, 1'b0});
    run_block(b, 64, -1, -1);
    drain();

    // downstream stall mid-block
    foreach (b[i]) b[i] = (i % 3 == 0) ? 8'(i) : 8'd0;
    run_block(b, 64, -1, 21);
    drain();

    // stray in_last on sample 10
    foreach (b[i]) b[i] = (i % 5 == 2) ? 8'(i * 7) : 8'd0;
    b[63] = 8'hF0;
    run_block(b, 64, 10, -1);
    drain();
    chk("err_last_set", {31'd0, err_last}, 1);
    foreach (b[i]) b[i] = 8'd0;
    b[0] = 8'd9;
    run_block(b, 64, -1, -1);
    drain();
    chk("err_last_sticky", {31'd0, err_last}, 1);

    // reset mid-block
    foreach (b[i]) b[i] = (i % 4 == 1) ? 8'(i + 100) : 8'd0;
    run_block(b, 30, -1, -1);
    chk_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 0);
    chk("abort_err_last", {31'd0, err_last}, 0);
    exp_q.delete();
    stq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_ready", {31'd0, in_ready}, 1);
    chk_en = 1'b1;
    foreach (b[i]) b[i] = 8'd0;
    b[0] = 8'd3;
    run_block(b, 64, -1, -1);
    drain();

    repeat (3) @(posedge clk);
    #1;
    chk("idle_out_valid", {31'd0, out_valid}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
